// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one bus transfer per load/store, aligns store data and
// extends load data, and owns the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic [31:0]         ex_instr,
  input  logic [4:0]          ex_rd,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [DATA_W-1:0]   ex_rdata2,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [2:0]          ex_funct3,
  input  logic [1:0]          ex_mem2reg,
  input  logic                ex_reg_write,
  input  logic                flush,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                wb_valid,
  output logic [ADDR_W-1:0]   wb_pc,
  output logic [31:0]         wb_instr,
  output logic [4:0]          wb_rd,
  output logic [DATA_W-1:0]   wb_alu_result,
  output logic [1:0]          wb_mem2reg,
  output logic                wb_reg_write,
  output logic [DATA_W-1:0]   wb_read_data,
  output logic [1:0]          wb_exc
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_kill;
  logic [ADDR_W-1:0]   r_addr, r_pc;
  logic [DATA_W-1:0]   r_wdata, r_alu;
  logic [NB-1:0]       r_wstrb;
  logic                r_we, r_rd_en, r_reg_write;
  logic [2:0]          r_funct3;
  logic [OFF_W-1:0]    r_off;
  logic [31:0]         r_instr;
  logic [4:0]          r_rd;
  logic [1:0]          r_mem2reg;

  logic [OFF_W-1:0]    w_off;
  logic [3:0]          w_size;
  logic                w_legal, w_misal, w_err, w_mem, w_go;
  logic [1:0]          w_exc_idle;
  logic [NB-1:0]       w_strb_base, w_wstrb;
  logic [DATA_W-1:0]   w_wdata, w_rsh, w_load;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_busy, w_ack, w_tmo, w_done, w_kill;

  // Access size and legality of the EX/MEM instruction
  always_comb begin
    w_size  = 4'd1;
    w_legal = 1'b1;
    case (ex_funct3)
      3'b000, 3'b100: w_size = 4'd1;
      3'b001, 3'b101: w_size = 4'd2;
      3'b010:         w_size = 4'd4;
      3'b011: begin w_size = 4'd8; w_legal = (DATA_W == 64); end
      3'b110: begin w_size = 4'd4; w_legal = (DATA_W == 64); end
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_off       = ex_alu_result[OFF_W-1:0];
  assign w_misal     = |(4'(w_off) & (w_size - 4'd1));
  assign w_err       = ~w_legal | w_misal;
  assign w_mem       = ex_mem_read | ex_mem_write;
  assign w_go        = ex_valid & ~flush & w_mem & ~w_err;
  assign w_exc_idle  = (ex_valid & ~flush & w_mem & w_err) ? 2'b01 : 2'b00;
  assign w_strb_base = NB'((16'd1 << w_size) - 16'd1);
  assign w_wstrb     = w_strb_base << w_off;
  assign w_wdata     = ex_rdata2 << {w_off, 3'b000};
  assign w_addr      = ADDR_W'(ex_alu_result) & ~ADDR_W'(NB - 1);

  assign w_busy = (r_state == BUSY);
  assign w_ack  = w_busy & mem_ack;
  assign w_tmo  = w_busy & ~mem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done = w_ack | w_tmo;
  assign w_kill = r_kill | flush;

  // Load lane selection and extension from the latched size/offset
  always_comb begin
    w_rsh = mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = DATA_W'($signed(w_rsh[7:0]));
      3'b001:  w_load = DATA_W'($signed(w_rsh[15:0]));
      3'b010:  w_load = DATA_W'($signed(w_rsh[31:0]));
      3'b100:  w_load = DATA_W'(w_rsh[7:0]);
      3'b101:  w_load = DATA_W'(w_rsh[15:0]);
      3'b110:  w_load = DATA_W'(w_rsh[31:0]);
      default: w_load = w_rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, stall and bus request
  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (r_state)
      IDLE: if (w_go) begin
        w_next = BUSY;
        stall  = 1'b1;
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = ~w_done;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = w_busy ? r_wstrb : '0;

  // Transfer context captured on entry to BUSY, wait counter and kill flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_kill <= 1'b0; r_addr <= '0; r_pc <= '0; r_wdata <= '0;
      r_alu <= '0; r_wstrb <= '0; r_we <= 1'b0; r_rd_en <= 1'b0;
      r_reg_write <= 1'b0; r_funct3 <= '0; r_off <= '0; r_instr <= '0;
      r_rd <= '0; r_mem2reg <= '0;
    end else if (r_state == IDLE) begin
      r_cnt  <= '0;
      r_kill <= 1'b0;
      if (w_go) begin
        r_addr      <= w_addr;
        r_wdata     <= w_wdata;
        r_wstrb     <= ex_mem_write ? w_wstrb : '0;
        r_we        <= ex_mem_write;
        r_rd_en     <= ex_mem_read;
        r_funct3    <= ex_funct3;
        r_off       <= w_off;
        r_pc        <= ex_pc;
        r_instr     <= ex_instr;
        r_rd        <= ex_rd;
        r_alu       <= ex_alu_result;
        r_mem2reg   <= ex_mem2reg;
        r_reg_write <= ex_reg_write;
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (flush) r_kill <= 1'b1;
    end
  end

  // MEM/WB register; a bubble is presented while a transfer is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0; wb_pc <= '0; wb_instr <= '0; wb_rd <= '0;
      wb_alu_result <= '0; wb_mem2reg <= '0; wb_reg_write <= 1'b0;
      wb_read_data <= '0; wb_exc <= 2'b00;
    end else if (r_state == IDLE && !w_go) begin
      wb_valid      <= ex_valid & ~flush;
      wb_pc         <= ex_pc;
      wb_instr      <= ex_instr;
      wb_rd         <= ex_rd;
      wb_alu_result <= ex_alu_result;
      wb_mem2reg    <= ex_mem2reg;
      wb_reg_write  <= ex_valid & ~flush & ex_reg_write & (w_exc_idle == 2'b00);
      wb_read_data  <= '0;
      wb_exc        <= w_exc_idle;
    end else if (w_done) begin
      wb_valid      <= ~w_kill;
      wb_pc         <= r_pc;
      wb_instr      <= r_instr;
      wb_rd         <= r_rd;
      wb_alu_result <= r_alu;
      wb_mem2reg    <= r_mem2reg;
      wb_reg_write  <= ~w_kill & ~w_tmo & r_reg_write;
      wb_read_data  <= (w_ack & r_rd_en) ? w_load : '0;
      wb_exc        <= (~w_kill & w_tmo) ? 2'b10 : 2'b00;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_exc       <= 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage (DATA_W=32, short timeout).
module tb_mem_access_stage;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic        clk, rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, flush;
  logic [31:0] ex_pc, ex_instr, ex_alu_result, ex_rdata2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_mem2reg;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_reg_write;
  logic [31:0] wb_pc, wb_instr, wb_alu_result, wb_read_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_mem2reg, wb_exc;

  mem_access_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rd(ex_rd), .ex_alu_result(ex_alu_result), .ex_rdata2(ex_rdata2),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_mem2reg(ex_mem2reg), .ex_reg_write(ex_reg_write), .flush(flush),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem2reg(wb_mem2reg),
    .wb_reg_write(wb_reg_write), .wb_read_data(wb_read_data), .wb_exc(wb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, alu, rdata;
    logic [4:0]  rd;
    logic [1:0]  m2r, exc;
    logic        rw, chk_rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;

  int          o_stall_cycles;
  logic        o_req1, o_we1, o_seen_req;
  logic [31:0] o_addr1, o_wdata1;
  logic [3:0]  o_strb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] rd,
                                             input int off);
    int sz;
    logic [31:0] v;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    v  = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (f3 < 3'd4 && v[8*sz-1])
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Drive one instruction until the stage accepts it, then check the MEM/WB register.
  task automatic run(input string name, input logic [31:0] alu, input logic [31:0] sdata,
                     input logic rd, input logic wr, input logic [2:0] f3, input logic rw,
                     input int ack_at, input logic [31:0] rdata, input int flush_at);
    exp_t e;
    int   sz, busy;
    logic legal, err, mem, done;
    mem   = rd | wr;
    sz    = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = mem & (!legal || (int'(alu[1:0]) % sz) != 0);
    e.valid  = (flush_at < 0);
    e.exc    = !e.valid ? 2'b00 : err ? 2'b01 : (mem && ack_at == 0) ? 2'b10 : 2'b00;
    e.rw     = rw & e.valid & (e.exc == 2'b00);
    e.pc     = 32'h1000 + 32'(seq * 4);
    e.instr  = $urandom;
    e.rd     = 5'(seq);
    e.m2r    = 2'(seq);
    e.alu    = alu;
    e.chk_rd = rd & e.valid & (e.exc == 2'b00);
    e.rdata  = load_model(f3, rdata, int'(alu[1:0]));
    sb.push_back(e);
    seq++;

    ex_valid = 1'b1; ex_pc = e.pc; ex_instr = e.instr; ex_rd = e.rd; ex_mem2reg = e.m2r;
    ex_alu_result = alu; ex_rdata2 = sdata; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_reg_write = rw;
    busy = 0; done = 1'b0; o_stall_cycles = 0; o_seen_req = 1'b0;
    o_req1 = 1'b0; o_we1 = 1'b0; o_addr1 = '0; o_wdata1 = '0; o_strb1 = '0;
    for (int c = 0; c < int'(TIMEOUT) + 20 && !done; c++) begin
      flush     = (busy == flush_at);
      mem_ack   = (ack_at > 0 && busy == ack_at);
      mem_rdata = rdata;
      #1;
      o_seen_req = o_seen_req | mem_req;
      if (busy == 1) begin
        o_req1 = mem_req; o_we1 = mem_we; o_addr1 = mem_addr;
        o_wdata1 = mem_wdata; o_strb1 = mem_wstrb;
      end
      if (!stall) done = 1'b1;
      else        o_stall_cycles++;
      @(posedge clk); #1;
      busy++;
    end
    ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    if (!done) chk({name, "_bound"}, 32'd0, 32'd1);
    e = sb.pop_front();
    chk({name, "_wb_valid"}, 32'(wb_valid), 32'(e.valid));
    chk({name, "_wb_reg_write"}, 32'(wb_reg_write), 32'(e.rw));
    chk({name, "_wb_exc"}, 32'(wb_exc), 32'(e.exc));
    if (e.valid) begin
      chk({name, "_wb_pc"}, wb_pc, e.pc);
      chk({name, "_wb_instr"}, wb_instr, e.instr);
      chk({name, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
      chk({name, "_wb_alu"}, wb_alu_result, e.alu);
      chk({name, "_wb_mem2reg"}, 32'(wb_mem2reg), 32'(e.m2r));
    end
    if (e.chk_rd) chk({name, "_wb_read_data"}, wb_read_data, e.rdata);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_instr = '0; ex_rd = '0;
    ex_alu_result = '0; ex_rdata2 = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; ex_mem2reg = '0; ex_reg_write = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_exc", 32'(wb_exc), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("alu", 32'h1234, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 0, 32'h0, -1);
    chk("alu_stall_cycles", 32'(o_stall_cycles), 32'd0);
    chk("alu_alu_value", wb_alu_result, 32'h1234);

    run("lb", 32'h103, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 3, 32'h80FF_FFFF, -1);
    chk("lb_stall_cycles", 32'(o_stall_cycles), 32'd3);
    chk("lb_req", 32'(o_req1), 32'd1);
    chk("lb_we", 32'(o_we1), 32'd0);
    chk("lb_wstrb", 32'(o_strb1), 32'd0);
    chk("lb_addr", o_addr1, 32'h100);
    chk("lb_value", wb_read_data, 32'hFFFF_FF80);

    run("sh", 32'h102, 32'hABCD, 1'b0, 1'b1, 3'd1, 1'b0, 1, 32'h0, -1);
    chk("sh_wdata", o_wdata1, 32'hABCD_0000);
    chk("sh_wstrb", 32'(o_strb1), 32'b1100);
    chk("sh_we", 32'(o_we1), 32'd1);
    chk("sh_addr", o_addr1, 32'h100);

    run("lw_mis", 32'h101, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1, 32'h0, -1);
    chk("lw_mis_no_req", 32'(o_seen_req), 32'd0);

    run("lhu", 32'h102, 32'h0, 1'b1, 1'b0, 3'd5, 1'b1, 2, 32'h8001_0000, -1);
    chk("lhu_value", wb_read_data, 32'h0000_8001);
    run("lh", 32'h102, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 2, 32'h8001_0000, -1);
    chk("lh_value", wb_read_data, 32'hFFFF_8001);
    run("lbu", 32'h101, 32'h0, 1'b1, 1'b0, 3'd4, 1'b1, 1, 32'h0000_F100, -1);
    run("sw", 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd2, 1'b0, 5, 32'h0, -1);
    chk("sw_wstrb", 32'(o_strb1), 32'b1111);
    chk("sw_wdata", o_wdata1, 32'hDEAD_BEEF);
    chk("sw_stall_cycles", 32'(o_stall_cycles), 32'd5);
    run("ld_illegal", 32'h200, 32'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1, 32'h0, -1);
    run("f3_111", 32'h200, 32'h0, 1'b1, 1'b0, 3'd7, 1'b1, 1, 32'h0, -1);
    chk("f3_111_no_req", 32'(o_seen_req), 32'd0);

    run("tmo", 32'h300, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 0, 32'h0, -1);
    chk("tmo_stall_cycles", 32'(o_stall_cycles), TIMEOUT);
    chk("tmo_idle_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    #1;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);

    run("flush_busy", 32'h104, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 4, 32'h1111_2222, 2);
    chk("flush_busy_stall_cycles", 32'(o_stall_cycles), 32'd4);
    run("flush_idle", 32'h105, 32'h55, 1'b0, 1'b1, 3'd0, 1'b1, 1, 32'h0, 0);
    chk("flush_idle_no_req", 32'(o_seen_req), 32'd0);

    ex_valid = 1'b1; ex_alu_result = 32'h108; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'd2; ex_reg_write = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy_req_after", 32'(mem_req), 32'd0);
    chk("rst_busy_wb_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0; ex_valid = 1'b0;
    @(posedge clk); #1;

    run("alu2", 32'h5678, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 0, 32'h0, -1);
    chk("alu2_stall_cycles", 32'(o_stall_cycles), 32'd0);
    chk("idle_no_req", 32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
